tristate_bus_arbiter: RTL
=========================

Name: tristate_bus_arbiter

Overview:
Round-robin arbiter that generates the enable and select controls for a set of tri-state bus drivers sharing one wire bundle. It sits directly upstream of the tri-state mux/driver cells. It guarantees that at most one driver is enabled at a time. It inserts a guaranteed all-disabled turnaround gap between owners so that no two drivers ever contend on the bus.

Parameters:
N_REQ, 4, number of requesting agents/drivers; legal range 2..8
MAX_HOLD, 8, maximum consecutive cycles one agent may own the bus before forced release; legal range ≥1
TURN_CYC, 1, number of all-disabled cycles between owners; legal range ≥1
IDX_W, $clog2(N_REQ), width of owner index (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-agent bus request; agent holds high while it wants the bus, drops to release
grant  output  N_REQ  one-hot registered grant; zero when no owner
drv_en  output  N_REQ  one-hot tri-state driver enable (connects to driver enable); equals grant
owner_idx  output  IDX_W  binary index of current owner (select for downstream mux); holds last owner when idle
bus_idle  output  1  high when no drv_en bit is set
preempt  output  1  one-cycle pulse when an owner is forced off by MAX_HOLD expiry

Behaviour:
- Reset is asynchronous, active-low. On rst_n=0, immediately (no clock edge) set:
  - state=IDLE, grant=0, drv_en=0, owner_idx=0, bus_idle=1, preempt=0
  - hold_cnt=0, turn_cnt=0
  - rr_last=N_REQ-1, so agent 0 has first priority.
- All outputs are registered; no combinational path from req to any output.
- Round-robin pick: scan from rr_last+1 upward, wrap modulo N_REQ, and take the first agent with req set.
- States:
  - IDLE: if req≠0, on next edge → OWN with grant/drv_en=one-hot(pick), owner_idx=pick, hold_cnt=0. Otherwise stay in IDLE. Latency is req sampled high at edge k → drv_en high after edge k+1.
  - OWN: hold_cnt increments each cycle.
    - Release: if req[owner_idx]=0 → TURN on the next edge. Clear grant/drv_en, set rr_last=owner_idx, turn_cnt=0.
    - Expiry: else if hold_cnt==MAX_HOLD-1 → same transition, and preempt=1 for exactly that one cycle.
    - An owner therefore drives for at most MAX_HOLD cycles.
  - TURN: drv_en=0, bus floats. turn_cnt increments.
    - When turn_cnt==TURN_CYC-1: if req≠0 → OWN with round-robin pick (no extra IDLE cycle), else → IDLE.
    - req is sampled only on that final TURN cycle.
- Fairness:
  - A released or preempted owner re-requesting immediately loses to any other pending requester.
  - If it is the sole requester, it wins again after the turnaround.
- Requests that rise and fall while another agent owns the bus are not latched; a request must be high when sampled.
- Invariants:
  - popcount(drv_en) ≤ 1 at all times.
  - Between any two distinct or repeated ownerships there are ≥TURN_CYC cycles with drv_en=0.
  - bus_idle == (drv_en==0).
- owner_idx keeps its last value in TURN/IDLE; it changes only when a new grant is issued.
- Reset asserted mid-OWN or mid-TURN forces the reset values asynchronously. After release, the first grant again favours agent 0.

Test Plan:
Common settings: N_REQ=4, MAX_HOLD=8, TURN_CYC=1.
1. Reset: hold rst_n=0, toggle req=4'b1111 → grant=0, drv_en=0, bus_idle=1, preempt=0, owner_idx=0 throughout.
2. Single request: req=4'b0100 at edge k, held 3 cycles, then dropped →
   - drv_en=4'b0100 and owner_idx=2 after edge k+1.
   - drv_en=0 one edge after req[2] falls, for 1 cycle.
   - Then IDLE with bus_idle=1.
3. All requesting: req=4'b1111 held from reset, each agent dropping req after 2 owned cycles and reraising →
   - Grant order is 0,1,2,3,0.
   - Each ownership is separated by exactly one cycle of drv_en=0.
4. Timeout, sole requester: req=4'b0010 held continuously →
   - drv_en=4'b0010 for exactly 8 cycles.
   - preempt=1 for one cycle.
   - 1 cycle with drv_en=0.
   - Then drv_en=4'b0010 again.
5. Timeout with a waiter: req[1] held, req[3] raised during agent 1's ownership → after agent 1's 8th cycle and turnaround, drv_en=4'b1000 and owner_idx=3.
6. Reset mid-ownership: while drv_en=4'b0001, pull rst_n low between clock edges → drv_en=0 and grant=0 immediately without a clock edge. After release with req=4'b1001, the first grant goes to agent 0.

Every scenario also checks popcount(drv_en)≤1 and bus_idle==(drv_en==0) on every cycle.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner select for shared tri-state drivers,
// with a hold limit and a guaranteed all-disabled gap between owners.
module tristate_bus_arbiter #(
  parameter int N_REQ = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] drv_en,
  output logic [IDX_W-1:0] owner_idx,
  output logic             bus_idle,
  output logic             preempt
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t r_state, w_state;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic [IDX_W-1:0] r_idx, w_idx, r_last, w_last, w_pick, w_c;
  logic [HW-1:0] r_hold, w_hold;
  logic [TW-1:0] r_turn, w_turn;
  logic r_idle, r_pre, w_pre, w_any, w_sel;
  // Scan nearest-first from r_last+1; descending loop so the closest requester wins.
  always_comb begin
    w_pick = '0;
    w_any = 1'b0;
    w_c = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_c = IDX_W'((int'(r_last) + i) % N_REQ);
      if (req[w_c]) begin
        w_any = 1'b1;
        w_pick = w_c;
      end
    end
  end
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_idx = r_idx;
    w_last = r_last;
    w_hold = r_hold;
    w_turn = r_turn;
    w_pre = 1'b0;
    case (r_state)
      OWN:
        if (!req[r_idx] || r_hold == HW'(MAX_HOLD - 1)) begin
          w_state = TURN;
          w_grant = '0;
          w_last = r_idx;
          w_turn = '0;
          w_pre = req[r_idx];
        end else w_hold = r_hold + 1'b1;
      TURN: w_turn = r_turn + 1'b1;
      default: ;
    endcase
    w_sel = r_state == IDLE || (r_state == TURN && r_turn == TW'(TURN_CYC - 1));
    if (w_sel && w_any) begin
      w_state = OWN;
      w_grant = N_REQ'(1) << w_pick;
      w_idx = w_pick;
      w_hold = '0;
    end else if (w_sel) w_state = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx <= '0;
      r_last <= IDX_W'(N_REQ - 1);
      r_hold <= '0;
      r_turn <= '0;
      r_idle <= 1'b1;
      r_pre <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_idx <= w_idx;
      r_last <= w_last;
      r_hold <= w_hold;
      r_turn <= w_turn;
      r_idle <= ~|w_grant;
      r_pre <= w_pre;
    end
  end
  assign grant = r_grant;
  assign drv_en = r_grant;
  assign owner_idx = r_idx;
  assign bus_idle = r_idle;
  assign preempt = r_pre;
endmodule
